// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALUOp,
// mux selects and FSM state numbering.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALUOP_FUNCT = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b001;
    localparam logic [2:0] ALUOP_SUB   = 3'b010;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_RD    = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_TRAP      = 4'd15
    } state_t;

    // States that sit on the memory ready handshake and are watchdog-guarded.
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive not-ready cycles in a memory wait state and flags expiry
// on the cycle the count reaches TIMEOUT_CYCLES with memory still not ready.
module mem_wait_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_wait,
    input  logic i_ready,
    output logic o_expire
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;

    assign w_stall = i_wait && !i_ready;

    // Any cycle not stalled (ready seen or outside a wait state) clears the
    // count, so every wait state is entered with a zero count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_expire = w_stall && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control FSM: Moore-decoded datapath strobes, ALUOp
// for the ALU control decoder, and a watchdog on variable-latency memory.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_dbg
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   r_timeout;
    logic   w_wait;
    logic   w_expire;
    logic   w_bad_op;

    assign w_wait = is_mem_wait(r_state);

    mem_wait_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wait   (w_wait),
        .i_ready  (mem_ready),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_bad_op) r_illegal <= 1'b1;
            if (w_expire) r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_bad_op      = 1'b0;
        alu_op        = ALUOP_FUNCT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;

        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)     w_next = ST_DECODE;
                else if (w_expire) w_next = ST_TRAP;
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:     w_next = ST_R_EXEC;
                    OP_LW, OP_SW: w_next = ST_MEM_ADDR;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_ADDI:      w_next = ST_ADDI_EXEC;
                    default: begin
                        w_next   = ST_TRAP;
                        w_bad_op = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                w_next    = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)     w_next = ST_MEM_WB;
                else if (w_expire) w_next = ST_TRAP;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)     w_next = ST_FETCH;
                else if (w_expire) w_next = ST_TRAP;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                w_next    = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                w_next        = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                w_next    = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
                w_next    = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_TRAP;
        endcase
    end

    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;
    assign state_dbg   = r_state;

endmodule
